// File: rtl/fm_demod_param_pkg.sv
// fm_radio_pkg: shared types and fixed-point helpers for the FM discriminator.
//   DEQUANTIZE / QUANTIZE : Q-format scale helpers, fraction width passed in
//   fm_demod_state_t      : discriminator FSM state encoding
//   QUAD1_Q / QUAD1       : pi/4 in Q(qbits) (804 at QBITS=10)
package fm_radio_pkg;

  // Wide enough for any 2*DATA_W product with DATA_W up to 64.
  localparam int ARITH_W = 128;
  typedef logic signed [ARITH_W-1:0] arith_t;

  typedef enum logic [2:0] {
    S_PRIME,
    S_IDLE,
    S_MULT,
    S_ARCTAN,
    S_OUTPUT
  } fm_demod_state_t;

  // Arithmetic shift right by qbits, rounding toward zero.
  function automatic arith_t DEQUANTIZE(input arith_t x, input int unsigned qbits);
    arith_t bias;
    bias = (arith_t'(1) <<< qbits) - arith_t'(1);
    return (x < 0) ? ((x + bias) >>> qbits) : (x >>> qbits);
  endfunction

  function automatic arith_t QUANTIZE(input arith_t x, input int unsigned qbits);
    return x <<< qbits;
  endfunction

  // pi/4 * 2^16 = 51471.85 -> 51472; rescale to qbits with rounding.
  function automatic int QUAD1_Q(input int unsigned qbits);
    longint q;
    q = (longint'(51472) << qbits) + longint'(32768);
    return int'(q >>> 16);
  endfunction

  localparam int QUAD1 = QUAD1_Q(10);

endpackage

// File: rtl/fm_demod_param_if.sv
// fm_demod_param_if: FIFO-facing bus of the discriminator.
//   in_empty / in_rd_en / real_in / imag_in : I/Q input FIFO pair (show-ahead head)
//   out_full / out_wr_en / demod_out         : audio output FIFO
// master: the discriminator (it drives both FIFO enables).
// slave : the FIFO side / environment.
interface fm_demod_param_if #(parameter int DATA_W = 32);
  logic                     in_empty;
  logic                     in_rd_en;
  logic signed [DATA_W-1:0] real_in;
  logic signed [DATA_W-1:0] imag_in;
  logic                     out_full;
  logic                     out_wr_en;
  logic signed [DATA_W-1:0] demod_out;

  modport master (
    input  in_empty, real_in, imag_in, out_full,
    output in_rd_en, out_wr_en, demod_out
  );

  modport slave (
    output in_empty, real_in, imag_in, out_full,
    input  in_rd_en, out_wr_en, demod_out
  );
endinterface

// File: rtl/fm_demod_param_qarctan.sv
// qarctan_param: quantized arctangent of (x, y) using a serial restoring divider.
//   start : 1-cycle pulse, x/y sampled on it
//   abort : drops any work in flight, no done is produced
//   angle : result in Q(QBITS), valid with done
//   done  : 1-cycle pulse
// x>=0 : QUAD1 - QUAD1*(x-|y|)/(x+|y|)
// x<0  : 3*QUAD1 - QUAD1*(x+|y|)/(|y|-x)
// negated for y<0. Division truncates toward zero. (0,0) gives angle 0.
// Latency: 1 cycle for (0,0), otherwise NW+2 cycles.
module qarctan_param import fm_radio_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int QBITS  = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] angle,
  output logic                     done
);

  localparam int EW = DATA_W + 2;          // room for x +/- |y| without overflow
  localparam int DW = DATA_W + 1;          // divisor magnitude width
  localparam int NW = DATA_W + QBITS + 2;  // dividend magnitude width
  localparam int CW = $clog2(NW + 1);
  localparam int Q1 = QUAD1_Q(QBITS);

  logic signed [EW-1:0] xe, ye, ay, n_s, d_s;
  logic        [EW-1:0] n_mag;
  logic        [NW-1:0] num;

  always_comb begin
    xe = EW'(x);
    ye = EW'(y);
    ay = ye[EW-1] ? -ye : ye;
    if (!xe[EW-1]) begin
      n_s = xe - ay;
      d_s = xe + ay;
    end else begin
      n_s = xe + ay;
      d_s = ay - xe;
    end
    n_mag = n_s[EW-1] ? -n_s : n_s;
    num   = NW'(n_mag) * NW'(Q1);
  end

  logic              busy, fin, neg_q, neg_y, far;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     rem, den;
  logic [NW-1:0]     quo;
  logic [DW:0]       rem_sh;
  logic              fits;
  logic signed [DATA_W-1:0] q_mag, base, ang;

  // One restoring step: dividend bits shift out of quo into rem, quotient bits shift in.
  always_comb begin
    rem_sh = {rem, quo[NW-1]};
    fits   = rem_sh >= {1'b0, den};
    // Quotient magnitude never exceeds QUAD1, so the low bits carry it all.
    q_mag  = quo[DATA_W-1:0];
    base   = far ? DATA_W'(3 * Q1) : DATA_W'(Q1);
    ang    = base - (neg_q ? -q_mag : q_mag);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      fin   <= 1'b0;
      neg_q <= 1'b0;
      neg_y <= 1'b0;
      far   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      den   <= '0;
      quo   <= '0;
      angle <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        fin  <= 1'b0;
      end else if (start) begin
        neg_q <= n_s[EW-1];
        neg_y <= y[DATA_W-1];
        far   <= x[DATA_W-1];
        den   <= d_s[DW-1:0];
        quo   <= num;
        rem   <= '0;
        cnt   <= CW'(NW);
        fin   <= 1'b0;
        if (d_s == '0) begin
          angle <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          busy <= 1'b1;
        end
      end else if (busy) begin
        rem <= fits ? DW'(rem_sh - {1'b0, den}) : rem_sh[DW-1:0];
        quo <= {quo[NW-2:0], fits};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          fin  <= 1'b1;
        end
      end else if (fin) begin
        fin   <= 1'b0;
        done  <= 1'b1;
        angle <= neg_y ? -ang : ang;
      end
    end
  end

endmodule

// File: rtl/fm_demod_param.sv
// fm_demod_param: FM discriminator between the I/Q filter FIFOs and the audio FIFO.
//   clk, reset_n : clock, async active-low reset
//   flush        : sync clear; abandons work, clears history, re-primes
//   bus          : fm_demod_param_if.master (input FIFO pop side, output FIFO push side)
// Per popped sample: cr/ci = DEQ(prev x conj-style curr), angle = qarctan(cr, ci),
// out = DEQ(angle*GAIN). The first sample after reset/flush emits PRIME_VALUE.
// Output writes are registered pulses; demod_out holds between writes.
module fm_demod_param import fm_radio_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int QBITS       = 10,
  parameter int GAIN        = 'h2F6,
  parameter int PRIME_VALUE = 'h4A6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  fm_demod_param_if.master  bus
);

  localparam int PW = 2 * DATA_W;

  fm_demod_state_t state, state_n;

  logic signed [DATA_W-1:0] re, im, prev_re, prev_im, cr, ci;
  logic signed [DATA_W-1:0] dout, angle;
  logic                     wr_q, start, done;
  logic                     pop, wr_n;
  logic signed [PW-1:0]     cr_sum, ci_sum, scaled;

  // Products and sums wrap at 2*DATA_W; DEQ sees the full-width sum.
  assign cr_sum = PW'(prev_re) * PW'(re) + PW'(prev_im) * PW'(im);
  assign ci_sum = PW'(prev_re) * PW'(im) - PW'(prev_im) * PW'(re);
  assign scaled = PW'(angle) * PW'(GAIN);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    wr_n    = 1'b0;
    if (flush) begin
      state_n = S_PRIME;
    end else begin
      case (state)
        // Prime only when the write can land, so a full output never loses it.
        S_PRIME:  if (!bus.in_empty && !bus.out_full) begin
                    pop     = 1'b1;
                    wr_n    = 1'b1;
                    state_n = S_IDLE;
                  end
        S_IDLE:   if (!bus.in_empty) begin
                    pop     = 1'b1;
                    state_n = S_MULT;
                  end
        S_MULT:   state_n = S_ARCTAN;
        S_ARCTAN: if (done) state_n = S_OUTPUT;
        S_OUTPUT: if (!bus.out_full) begin
                    wr_n    = 1'b1;
                    state_n = S_IDLE;
                  end
        default:  state_n = S_PRIME;
      endcase
    end
  end

  // Pop is combinational against the FIFO head; reset_n gates it because the
  // reset state (PRIME) would otherwise request a pop while held in reset.
  assign bus.in_rd_en  = pop & reset_n;
  assign bus.out_wr_en = wr_q;
  assign bus.demod_out = dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_PRIME;
      re      <= '0;
      im      <= '0;
      prev_re <= '0;
      prev_im <= '0;
      cr      <= '0;
      ci      <= '0;
      dout    <= '0;
      wr_q    <= 1'b0;
      start   <= 1'b0;
    end else begin
      state <= state_n;
      wr_q  <= wr_n;
      start <= 1'b0;
      if (flush) begin
        re      <= '0;
        im      <= '0;
        prev_re <= '0;
        prev_im <= '0;
        cr      <= '0;
        ci      <= '0;
      end else begin
        if (pop) begin
          prev_re <= re;
          prev_im <= im;
          re      <= bus.real_in;
          im      <= bus.imag_in;
        end
        if (state == S_PRIME && pop) dout <= DATA_W'(PRIME_VALUE);
        if (state == S_MULT) begin
          cr    <= DATA_W'(DEQUANTIZE(ARITH_W'(cr_sum), QBITS));
          ci    <= DATA_W'(DEQUANTIZE(ARITH_W'(ci_sum), QBITS));
          start <= 1'b1;
        end
        if (state == S_ARCTAN && done)
          dout <= DATA_W'(DEQUANTIZE(ARITH_W'(scaled), QBITS));
      end
    end
  end

  qarctan_param #(
    .DATA_W (DATA_W),
    .QBITS  (QBITS)
  ) u_arctan (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (flush),
    .x       (cr),
    .y       (ci),
    .angle   (angle),
    .done    (done)
  );

endmodule

// File: tb/tb_fm_demod_param.sv
module tb_fm_demod_param;

  localparam int DW    = 32;
  localparam int PRIME = 'h4A6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  fm_demod_param_if #(.DATA_W(DW)) bus();

  fm_demod_param #(
    .DATA_W(DW), .QBITS(10), .GAIN('h2F6), .PRIME_VALUE('h4A6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int re; int im; } samp_t;

  samp_t  in_q[$];
  longint exp_q[$];
  int     compared = 0, mismatched = 0, pop_cnt = 0;
  bit     have_hist = 1'b0;
  samp_t  hist;
  logic   last_rd, last_wr;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Reference: cross products, DEQ by truncating division, arctan formula, gain.
  function automatic longint model_word(samp_t p, samp_t c);
    longint crs, cis, x, y, ay, n, d, base, ang;
    crs = longint'(p.re) * longint'(c.re) + longint'(p.im) * longint'(c.im);
    cis = longint'(p.re) * longint'(c.im) - longint'(p.im) * longint'(c.re);
    x = longint'(int'(crs / 1024));
    y = longint'(int'(cis / 1024));
    ay = (y < 0) ? -y : y;
    if (x >= 0) begin n = x - ay; d = x + ay; base = 804; end
    else        begin n = x + ay; d = ay - x; base = 3 * 804; end
    ang = (d == 0) ? 0 : base - (804 * n) / d;
    if (y < 0) ang = -ang;
    return longint'(int'((ang * 758) / 1024));
  endfunction

  task automatic drive();
    bus.in_empty = (in_q.size() == 0);
    bus.real_in  = (in_q.size() > 0) ? in_q[0].re : 0;
    bus.imag_in  = (in_q.size() > 0) ? in_q[0].im : 0;
  endtask

  task automatic push_s(input int re, input int im, input bit lit, input longint v);
    samp_t s;
    s.re = re; s.im = im;
    in_q.push_back(s);
    if (lit)            exp_q.push_back(v);
    else if (!have_hist) exp_q.push_back(longint'(PRIME));
    else                exp_q.push_back(model_word(hist, s));
    hist = s;
    have_hist = 1'b1;
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    last_rd = bus.in_rd_en;
    last_wr = bus.out_wr_en;
    if (last_rd) begin
      pop_cnt++;
      check("pop_nonempty", 64'(in_q.size() > 0), 64'd1);
    end
    if (last_wr) begin
      check("wr_not_full", 64'(bus.out_full), 64'd0);
      check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("word", 64'(bus.demod_out), exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (last_rd && in_q.size() > 0) void'(in_q.pop_front());
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (5) cycle();
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check("pops_reached", 64'(pop_cnt >= target), 64'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    have_hist = 1'b0;
    check("flush_no_pop", 64'(last_rd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.out_full = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", 64'(bus.out_wr_en), 64'd0);
    check("rst_dout", 64'(bus.demod_out), 64'd0);
    reset_n = 1'b1;

    // angle 0
    push_s(1024, 0, 1, longint'(PRIME));
    push_s(1024, 0, 1, 0);
    drain(400);

    // +90 degrees: angle 1608 -> 1190
    do_flush();
    push_s(1024, 0, 1, longint'(PRIME));
    push_s(0, 1024, 1, 1190);
    drain(400);

    // -90 degrees: rounds toward zero -> -1190
    do_flush();
    push_s(1024, 0, 1, longint'(PRIME));
    push_s(0, -1024, 1, -1190);
    drain(400);

    // mixed quadrants and wrapping magnitudes
    do_flush();
    push_s(1000, 300, 0, 0);
    push_s(700, -500, 0, 0);
    push_s(-800, 200, 0, 0);
    push_s(-300, -900, 0, 0);
    push_s(32'h4000_0000, 32'h1234_5678, 0, 0);
    push_s(-805306368, 1879048192, 0, 0);
    push_s(5, 3, 0, 0);
    drain(800);

    // out_full held at PRIME, then at OUTPUT
    do_flush();
    bus.out_full = 1'b1;
    push_s(900, 100, 0, 0);
    push_s(-400, 600, 0, 0);
    push_s(200, -700, 0, 0);
    repeat (20) begin
      cycle();
      check("full_prime_pop", 64'(last_rd), 64'd0);
      check("full_prime_wr", 64'(last_wr), 64'd0);
    end
    bus.out_full = 1'b0;
    base = pop_cnt;
    wait_pops(base + 2, 40);
    bus.out_full = 1'b1;
    repeat (80) begin
      cycle();
      check("full_out_pop", 64'(last_rd), 64'd0);
      check("full_out_wr", 64'(last_wr), 64'd0);
    end
    bus.out_full = 1'b0;
    drain(400);

    // flush while the third sample is in ARCTAN
    do_flush();
    base = pop_cnt;
    push_s(1024, 0, 0, 0);
    push_s(600, 800, 0, 0);
    push_s(-500, 500, 0, 0);
    wait_pops(base + 3, 400);
    repeat (4) cycle();
    check("s3_pending", 64'(exp_q.size()), 64'd1);
    do_flush();
    exp_q.delete();
    push_s(300, -200, 0, 0);
    push_s(-100, 700, 0, 0);
    drain(400);

    // async reset mid-ARCTAN
    do_flush();
    base = pop_cnt;
    push_s(1024, 0, 0, 0);
    push_s(0, 1024, 0, 0);
    wait_pops(base + 2, 40);
    repeat (6) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wr", 64'(bus.out_wr_en), 64'd0);
    check("arst_rd", 64'(bus.in_rd_en), 64'd0);
    check("arst_dout", 64'(bus.demod_out), 64'd0);
    in_q.delete();
    exp_q.delete();
    have_hist = 1'b0;
    push_s(1024, 0, 1, longint'(PRIME));
    push_s(0, 1024, 1, 1190);
    @(negedge clk);
    check("rd_in_reset", 64'(bus.in_rd_en), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
